// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Captures decoded control, operands and register indices from ID every cycle.
// A load in EX whose destination is read by the ID instruction freezes PC and
// IF/ID for one cycle and sends a bubble into EX. A flush squashes the ID
// instruction by loading a bubble, and no stall is raised for that instruction.
// A saturating counter records how many load-use bubbles have been inserted.

module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,

    // Decoded control, operands and indices from ID
    input  logic              ID_RegWrite,
    input  logic              ID_MemToReg,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic [1:0]        ID_ALUOp,
    input  logic [DATA_W-1:0] ID_RD1,
    input  logic [DATA_W-1:0] ID_RD2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [REG_W-1:0]  ID_RegRs,
    input  logic [REG_W-1:0]  ID_RegRt,
    input  logic [REG_W-1:0]  ID_RegRd,

    // Registered copies presented to EX and to the forwarding unit
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemToReg,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_ALUSrc,
    output logic              ID_EX_RegDst,
    output logic [1:0]        ID_EX_ALUOp,
    output logic [DATA_W-1:0] ID_EX_RD1,
    output logic [DATA_W-1:0] ID_EX_RD2,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic [REG_W-1:0]  ID_EX_RegRs,
    output logic [REG_W-1:0]  ID_EX_RegRt,
    output logic [REG_W-1:0]  ID_EX_RegRd,
    output logic [REG_W-1:0]  ID_EX_WriteReg,

    // Hazard control back to the front of the pipeline
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic [CNT_W-1:0]  stall_count_o
);

    // Everything that travels from ID to EX, held as one word so that a
    // bubble is a single all-zero assignment.
    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src;
        logic              reg_dst;
        logic [1:0]        alu_op;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } id_ex_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    id_ex_t            id_fields;
    id_ex_t            ex_d;
    id_ex_t            ex_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic              hazard;
    logic              load_use;
    logic              bubble;

    assign id_fields = '{
        reg_write:  ID_RegWrite,
        mem_to_reg: ID_MemToReg,
        mem_read:   ID_MemRead,
        mem_write:  ID_MemWrite,
        alu_src:    ID_ALUSrc,
        reg_dst:    ID_RegDst,
        alu_op:     ID_ALUOp,
        rd1:        ID_RD1,
        rd2:        ID_RD2,
        imm:        ID_Imm,
        rs:         ID_RegRs,
        rt:         ID_RegRt,
        rd:         ID_RegRd
    };

    // Detect a load in EX feeding the ID instruction and decide what enters EX next.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block can leave one unassigned and infer a latch.
        ex_d        = id_fields;
        stall_cnt_d = stall_cnt_q;

        // Register 0 is hard-wired, so a load targeting it never creates a dependency.
        hazard   = ex_q.mem_read && (ex_q.rt != '0) &&
                   ((ex_q.rt == ID_RegRs) || (ex_q.rt == ID_RegRt));
        // A squashed instruction never executes, so it has nothing to wait for.
        load_use = hazard && !flush_i;
        bubble   = flush_i || load_use;

        // Zeroed indices also guarantee the bubble never matches in forwarding.
        if (bubble) begin
            ex_d = '0;
        end

        // Only load-use bubbles are counted, and the count sticks at its maximum.
        if (load_use && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Pipeline register and stall counter, cleared asynchronously on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: all state here is plain flops (no memory arrays), so every bit
        // is reset and nothing unknown can reach the hazard compare.
        if (rst_i) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ID_EX_RegWrite = ex_q.reg_write;
    assign ID_EX_MemToReg = ex_q.mem_to_reg;
    assign ID_EX_MemRead  = ex_q.mem_read;
    assign ID_EX_MemWrite = ex_q.mem_write;
    assign ID_EX_ALUSrc   = ex_q.alu_src;
    assign ID_EX_RegDst   = ex_q.reg_dst;
    assign ID_EX_ALUOp    = ex_q.alu_op;
    assign ID_EX_RD1      = ex_q.rd1;
    assign ID_EX_RD2      = ex_q.rd2;
    assign ID_EX_Imm      = ex_q.imm;
    assign ID_EX_RegRs    = ex_q.rs;
    assign ID_EX_RegRt    = ex_q.rt;
    assign ID_EX_RegRd    = ex_q.rd;

    // Destination register selected from the registered RegDst.
    assign ID_EX_WriteReg = ex_q.reg_dst ? ex_q.rd : ex_q.rt;

    // Freeze PC and IF/ID while the bubble is inserted so ID is replayed.
    assign PC_Write       = !load_use;
    assign IF_ID_Write    = !load_use;

    assign stall_count_o  = stall_cnt_q;

endmodule
